// File: rtl/ili9486_bus_receiver.sv
// 8080-bus responder for the ILI9486 CASET/PASET/RAMWR subset: synchronizes the
// asynchronous bus, decodes commands and streams assembled pixels over AXI stream.
module ili9486_bus_receiver #(
  parameter int SYNC_STAGES           = 2,
  parameter int STREAM_COLORMODE_RGBA = 0,
  parameter int DEFAULT_EC            = 319,
  parameter int DEFAULT_EP            = 479
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        wr,
  input  logic        rd,
  input  logic        cs,
  input  logic        dc,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        overflow
);

  localparam logic [15:0] EC_RST = 16'(DEFAULT_EC);
  localparam logic [15:0] EP_RST = 16'(DEFAULT_EP);

  typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, SKIP} state_t;

  function automatic logic [15:0] color_map(input logic [15:0] p);
    if (STREAM_COLORMODE_RGBA != 0)
      color_map = {p[15:12], p[10:7], p[4:1], 4'hF};
    else
      color_map = p;
  endfunction

  logic unused_rd;
  assign unused_rd = rd;

  // Stage p0: synchronizer chains
  logic [SYNC_STAGES-1:0] cs_p0;
  logic [SYNC_STAGES-1:0] wr_p0;
  logic [SYNC_STAGES-1:0] dc_p0;
  logic [7:0]             data_p0 [SYNC_STAGES];

  always_ff @(posedge aclk) begin
    if (reset) begin
      cs_p0 <= '1;
      wr_p0 <= '1;
    end else begin
      cs_p0 <= {cs_p0[SYNC_STAGES-2:0], cs};
      wr_p0 <= {wr_p0[SYNC_STAGES-2:0], wr};
    end
  end

  always_ff @(posedge aclk) begin
    dc_p0      <= {dc_p0[SYNC_STAGES-2:0], dc};
    data_p0[0] <= data;
    for (int i = 1; i < SYNC_STAGES; i++)
      data_p0[i] <= data_p0[i-1];
  end

  logic       cs_s, wr_s, dc_s;
  logic [7:0] data_s;
  assign cs_s   = cs_p0[SYNC_STAGES-1];
  assign wr_s   = wr_p0[SYNC_STAGES-1];
  assign dc_s   = dc_p0[SYNC_STAGES-1];
  assign data_s = data_p0[SYNC_STAGES-1];

  // Stage p1: write-edge detection and byte decode
  logic wr_prev_p1;
  always_ff @(posedge aclk) begin
    if (reset) wr_prev_p1 <= 1'b1;
    else       wr_prev_p1 <= wr_s;
  end

  logic wr_evt, cmd_evt, dat_evt;
  assign wr_evt  = wr_s & ~wr_prev_p1 & ~cs_s;
  assign cmd_evt = wr_evt & ~dc_s;
  assign dat_evt = wr_evt & dc_s;

  state_t      state;
  logic [1:0]  par_cnt;
  logic        byte_phase;
  logic [15:0] sc, ec, sp, ep, x, y;
  logic [7:0]  start_hi_p1, start_lo_p1, end_hi_p1, pix_hi_p1;

  // Partial-value holding registers carry no reset; the counters qualify them.
  always_ff @(posedge aclk) begin
    if (dat_evt) begin
      if (state == CASET || state == PASET) begin
        case (par_cnt)
          2'd0:    start_hi_p1 <= data_s;
          2'd1:    start_lo_p1 <= data_s;
          2'd2:    end_hi_p1   <= data_s;
          default: ;
        endcase
      end
      if (state == RAMWR && !byte_phase) pix_hi_p1 <= data_s;
    end
  end

  logic        pix_done;
  logic [15:0] pix_word;
  assign pix_done = dat_evt && (state == RAMWR) && byte_phase;
  assign pix_word = {pix_hi_p1, data_s};

  // Stage p2: position tracking and single-entry output register
  always_ff @(posedge aclk) begin
    if (reset) begin
      state         <= IDLE;
      par_cnt       <= 2'd0;
      byte_phase    <= 1'b0;
      sc            <= 16'd0;
      ec            <= EC_RST;
      sp            <= 16'd0;
      ep            <= EP_RST;
      x             <= 16'd0;
      y             <= 16'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 16'd0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (cs_s) byte_phase <= 1'b0;

      if (cmd_evt) begin
        byte_phase <= 1'b0;
        par_cnt    <= 2'd0;
        case (data_s)
          8'h2A:   state <= CASET;
          8'h2B:   state <= PASET;
          8'h2C: begin
            state <= RAMWR;
            x     <= sc;
            y     <= sp;
          end
          default: state <= SKIP;
        endcase
      end else if (dat_evt) begin
        case (state)
          CASET, PASET: begin
            par_cnt <= par_cnt + 2'd1;
            if (par_cnt == 2'd3) begin
              if (state == CASET) begin
                sc <= {start_hi_p1, start_lo_p1};
                ec <= {end_hi_p1, data_s};
              end else begin
                sp <= {start_hi_p1, start_lo_p1};
                ep <= {end_hi_p1, data_s};
              end
              state <= IDLE;
            end
          end
          RAMWR: begin
            byte_phase <= ~byte_phase;
            if (byte_phase) begin
              if (x == ec) begin
                x <= sc;
                y <= (y == ep) ? sp : y + 16'd1;
              end else begin
                x <= x + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end

      // A pixel finishing while the register is stalled has nowhere to go.
      if (pix_done) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= color_map(pix_word);
          m_axis_tuser  <= (x == sc) && (y == sp);
          m_axis_tlast  <= (x == ec);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ili9486_bus_receiver.sv
// Scoreboard bench: stimulus pushes expected beats, negedge monitors pop and compare.
module tb_ili9486_bus_receiver;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        wr = 1'b1;
  logic        rd = 1'b1;
  logic        cs = 1'b1;
  logic        dc = 1'b1;
  logic        tready = 1'b1;
  logic        tready2 = 1'b1;
  logic        tvalid, tuser, tlast, ovf;
  logic [15:0] tdata;
  logic        tvalid2, tuser2, tlast2, ovf2;
  logic [15:0] tdata2;

  always #5 aclk = ~aclk;

  ili9486_bus_receiver #(.STREAM_COLORMODE_RGBA(0)) dut (
    .aclk(aclk), .reset(reset), .data(data), .wr(wr), .rd(rd), .cs(cs), .dc(dc),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast), .overflow(ovf));

  ili9486_bus_receiver #(.STREAM_COLORMODE_RGBA(1)) dut_rgba (
    .aclk(aclk), .reset(reset), .data(data), .wr(wr), .rd(rd), .cs(cs), .dc(dc),
    .m_axis_tvalid(tvalid2), .m_axis_tready(tready2), .m_axis_tdata(tdata2),
    .m_axis_tuser(tuser2), .m_axis_tlast(tlast2), .overflow(ovf2));

  typedef struct packed {
    logic [15:0] d;
    logic        u;
    logic        l;
  } beat_t;

  beat_t q1[$];
  beat_t q2[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon2_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge aclk) begin
    beat_t b;
    if (!reset && tvalid && tready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none at %0t", tdata, $time);
      end else begin
        b = q1.pop_front();
        chk("beat_tdata", 32'(tdata), 32'(b.d));
        chk("beat_tuser", 32'(tuser), 32'(b.u));
        chk("beat_tlast", 32'(tlast), 32'(b.l));
      end
    end
  end

  always @(negedge aclk) begin
    beat_t b;
    if (!reset && mon2_en && tvalid2 && tready2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rgba_beat: got %0h expected none at %0t", tdata2, $time);
      end else begin
        b = q2.pop_front();
        chk("rgba_tdata", 32'(tdata2), 32'(b.d));
        chk("rgba_tuser", 32'(tuser2), 32'(b.u));
        chk("rgba_tlast", 32'(tlast2), 32'(b.l));
      end
    end
  end

  task automatic wrb(input logic d_c, input logic [7:0] b);
    dc   = d_c;
    data = b;
    wr   = 1'b0;
    repeat (4) @(posedge aclk);
    wr   = 1'b1;
    repeat (4) @(posedge aclk);
  endtask

  task automatic cmd(input logic [7:0] b);
    wrb(1'b0, b);
  endtask

  task automatic px(input logic [15:0] p);
    wrb(1'b1, p[15:8]);
    wrb(1'b1, p[7:0]);
  endtask

  task automatic exp1(input logic [15:0] d, input logic u, input logic l);
    beat_t b;
    b = '{d: d, u: u, l: l};
    q1.push_back(b);
  endtask

  task automatic exp2(input logic [15:0] d, input logic u, input logic l);
    beat_t b;
    b = '{d: d, u: u, l: l};
    q2.push_back(b);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
      @(posedge aclk);
      n++;
    end
    chk(name, 32'(q1.size() + q2.size()), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tvalid"}, 32'(tvalid), 32'd0);
    chk({tag, "_tdata"}, 32'(tdata), 32'd0);
    chk({tag, "_tuser"}, 32'(tuser), 32'd0);
    chk({tag, "_tlast"}, 32'(tlast), 32'd0);
    chk({tag, "_overflow"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    repeat (4) @(posedge aclk);
    #1;
    chk_zero_outputs("reset");
    reset = 1'b0;
    cs    = 1'b0;
    repeat (3) @(posedge aclk);

    // Basic RAMWR at default window
    exp1(16'hF800, 1'b1, 1'b0);
    exp1(16'h07E0, 1'b0, 1'b0);
    cmd(8'h2C);
    px(16'hF800);
    px(16'h07E0);
    drain("drain_basic");

    // Small window with wrap: columns 2..4, pages 0..1
    cmd(8'h2A); wrb(1'b1, 8'h00); wrb(1'b1, 8'h02); wrb(1'b1, 8'h00); wrb(1'b1, 8'h04);
    cmd(8'h2B); wrb(1'b1, 8'h00); wrb(1'b1, 8'h00); wrb(1'b1, 8'h00); wrb(1'b1, 8'h01);
    for (int i = 0; i < 7; i++)
      exp1(16'h0100 + 16'(i), (i == 0 || i == 6), (i == 2 || i == 5));
    cmd(8'h2C);
    for (int i = 0; i < 7; i++) px(16'h0100 + 16'(i));
    drain("drain_window");

    // Partial pixel discarded by a new command
    exp1(16'h1234, 1'b1, 1'b0);
    cmd(8'h2C);
    wrb(1'b1, 8'hAB);
    cmd(8'h2C);
    px(16'h1234);
    drain("drain_partial");

    // RGBA4444 conversion on the second instance
    mon2_en = 1'b1;
    exp1(16'hFFFF, 1'b1, 1'b0);
    exp1(16'h8410, 1'b0, 1'b0);
    exp2(16'hFFFF, 1'b1, 1'b0);
    exp2(16'h888F, 1'b0, 1'b0);
    cmd(8'h2C);
    px(16'hFFFF);
    px(16'h8410);
    drain("drain_rgba");
    mon2_en = 1'b0;

    // Backpressure: first pixel held, later ones dropped
    #1;
    tready = 1'b0;
    exp1(16'h1111, 1'b1, 1'b0);
    cmd(8'h2C);
    px(16'h1111);
    px(16'h2222);
    px(16'h3333);
    repeat (2) @(posedge aclk);
    #1;
    chk("bp_tvalid", 32'(tvalid), 32'd1);
    chk("bp_tdata", 32'(tdata), 32'h1111);
    chk("bp_overflow", 32'(ovf), 32'd1);
    tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("bp_tvalid_after", 32'(tvalid), 32'd0);
    drain("drain_bp");

    // Writes with cs high must not reprogram the window
    cs = 1'b1;
    repeat (4) @(posedge aclk);
    cmd(8'h2A); wrb(1'b1, 8'h00); wrb(1'b1, 8'h00); wrb(1'b1, 8'h00); wrb(1'b1, 8'h09);
    px(16'h5555);
    cs = 1'b0;
    repeat (4) @(posedge aclk);
    exp1(16'hA001, 1'b1, 1'b0);
    exp1(16'hA002, 1'b0, 1'b0);
    exp1(16'hA003, 1'b0, 1'b1);
    cmd(8'h2C);
    px(16'hA001);
    px(16'hA002);
    px(16'hA003);
    drain("drain_cs");

    // Reset in the middle of CASET restores defaults
    cmd(8'h2A);
    wrb(1'b1, 8'h00);
    wrb(1'b1, 8'h01);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk_zero_outputs("midreset");
    reset = 1'b0;
    repeat (3) @(posedge aclk);
    for (int i = 0; i < 5; i++)
      exp1(16'hC000 + 16'(i), (i == 0), 1'b0);
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) px(16'hC000 + 16'(i));
    drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
